tweet_tx_sequencer: RTL and testbench

Controller between the UART receiver, an internal message buffer and the UART transmitter of the tweetboard.
- Collects received bytes into a message buffer of up to MAX_LEN bytes.
- Debounces the write button. On a valid press, sequences the stored message out through the UART transmitter byte by byte.
- After the send completes, clears the buffer and returns to collecting.

---
 rtl/tweet_tx_sequencer.sv | 166 ++++++++++++++++
 tb/tb_tweet_tx_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tweet_tx_sequencer.sv
// rtl/tweet_tx_sequencer.sv - collects UART rx bytes, debounces btn_write and replays the buffer to UART tx
// Optional ECHO_EN: echo every stored byte back through the UART tx while collecting.
module tweet_tx_sequencer #(
  parameter int MAX_LEN         = 140,
  parameter int LEN_W           = 8,
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  input  logic             btn_write,
  input  logic             tx_busy,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  output logic             sending,
  output logic [LEN_W-1:0] msg_len,
  output logic             overflow
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  typedef enum logic [2:0] {
    S_COLLECT, S_LOAD, S_START, S_HOLD, S_WAIT, S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic             db_level_q, db_level_d;
  logic             db_prev_q;
  logic [LEN_W-1:0] msg_len_q, msg_len_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             sending_q, sending_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       mem_q [MAX_LEN];

  logic press, rx_store, launch, go, last_byte;

  always_comb begin
    db_cnt_d   = '0;
    db_level_d = db_level_q;
    if (btn_write != db_level_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_level_d = btn_write;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  assign press     = db_level_q & ~db_prev_q;
  assign rx_store  = rx_valid && (state_q == S_COLLECT) && (msg_len_q < LEN_MAX);
  assign last_byte = (idx_q == msg_len_q - 1'b1);

`ifdef ECHO_EN
  logic echo_q, echo_d, pend_q, pend_d, hold_off;

  // A send must not start while an echo frame is starting or still on the wire.
  assign echo_d   = rx_store & ~tx_busy;
  assign hold_off = echo_d | echo_q | tx_busy;
  assign launch   = (press | pend_q) & ~hold_off;
  assign pend_d   = (state_q == S_COLLECT) && (press || pend_q) && hold_off && (msg_len_q != '0);

  always_ff @(posedge sysclk) begin
    if (reset) begin
      echo_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      echo_q <= echo_d;
      pend_q <= pend_d;
    end
  end
`else
  assign launch = press;
`endif

  assign go = (state_q == S_COLLECT) && launch && (msg_len_q != '0);

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q <= S_COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_COLLECT: if (go) state_d = S_LOAD;
      S_LOAD:    state_d = S_START;
      S_START:   state_d = S_HOLD;
      S_HOLD:    state_d = S_WAIT;
      S_WAIT:    if (!tx_busy) state_d = last_byte ? S_DONE : S_LOAD;
      S_DONE:    state_d = S_COLLECT;
      default:   state_d = S_COLLECT;
    endcase
  end

  always_comb begin
    msg_len_d  = msg_len_q;
    idx_d      = idx_q;
    tx_data_d  = tx_data_q;
    sending_d  = sending_q;
    overflow_d = overflow_q | (rx_valid & ~rx_store);
    tx_start   = (state_q == S_START);
`ifdef ECHO_EN
    tx_start = tx_start | echo_q;
    if (echo_d) tx_data_d = rx_data;
`endif
    case (state_q)
      S_COLLECT: begin
        if (rx_store) msg_len_d = msg_len_q + 1'b1;
        if (go)       idx_d     = '0;
      end
      S_LOAD: begin
        tx_data_d = mem_q[idx_q];
        sending_d = 1'b1;
      end
      S_WAIT: begin
        if (!tx_busy && !last_byte) idx_d = idx_q + 1'b1;
      end
      S_DONE: begin
        msg_len_d = '0;
        sending_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      db_cnt_q   <= '0;
      db_level_q <= 1'b0;
      db_prev_q  <= 1'b0;
      msg_len_q  <= '0;
      idx_q      <= '0;
      tx_data_q  <= '0;
      sending_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      db_cnt_q   <= db_cnt_d;
      db_level_q <= db_level_d;
      db_prev_q  <= db_level_q;
      msg_len_q  <= msg_len_d;
      idx_q      <= idx_d;
      tx_data_q  <= tx_data_d;
      sending_q  <= sending_d;
      overflow_q <= overflow_d;
    end
  end

  // Buffer contents survive reset; only msg_len decides what is valid.
  always_ff @(posedge sysclk) begin
    if (rx_store) mem_q[msg_len_q] <= rx_data;
  end

  assign tx_data  = tx_data_q;
  assign sending  = sending_q;
  assign msg_len  = msg_len_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_tweet_tx_sequencer.sv
// tb/tb_tweet_tx_sequencer.sv - scoreboard bench for tweet_tx_sequencer with a simple UART tx busy model
module tb_tweet_tx_sequencer;

  localparam int MAX_LEN = 140;
  localparam int LEN_W   = 8;
  localparam int DB      = 32;
  localparam int BUSY    = 8;

  logic             sysclk    = 1'b0;
  logic             reset     = 1'b1;
  logic             rx_valid  = 1'b0;
  logic [7:0]       rx_data   = 8'h00;
  logic             btn_write = 1'b0;
  logic             tx_busy   = 1'b0;
  logic             tx_start;
  logic [7:0]       tx_data;
  logic             sending;
  logic [LEN_W-1:0] msg_len;
  logic             overflow;

  int checks    = 0;
  int failures  = 0;
  int cyc       = 0;
  int tx_cnt    = 0;
  int busy_cnt  = 0;
  int lat_cyc   = 0;
  int press_cyc = 0;
  int base      = 0;
  int n         = 0;
  bit arm       = 1'b0;
  bit in_send   = 1'b0;

  logic [7:0] model_buf[$];
  logic [7:0] exp_q[$];

  tweet_tx_sequencer #(
    .MAX_LEN(MAX_LEN),
    .LEN_W(LEN_W),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .sysclk(sysclk),
    .reset(reset),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .btn_write(btn_write),
    .tx_busy(tx_busy),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .sending(sending),
    .msg_len(msg_len),
    .overflow(overflow)
  );

  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #2;
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    if (!in_send && model_buf.size() < MAX_LEN) model_buf.push_back(b);
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic press_hi();
    if (model_buf.size() > 0) begin
      foreach (model_buf[i]) exp_q.push_back(model_buf[i]);
      model_buf.delete();
      in_send = 1'b1;
      arm     = 1'b1;
    end
    btn_write = 1'b1;
    press_cyc = cyc;
    repeat (DB + 4) tick();
    btn_write = 1'b0;
  endtask

  task automatic release_btn();
    repeat (DB + 4) tick();
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || sending) && k < 4000) begin
      tick();
      k++;
    end
    check_eq(tag, k < 4000, 1'b1);
    in_send = 1'b0;
  endtask

  task automatic check_lat();
    check_eq("first_tx_latency", 32'(lat_cyc - press_cyc), DB + 2);
  endtask

  // UART tx model and scoreboard: busy for BUSY cycles after each tx_start.
  initial begin
    forever begin
      @(posedge sysclk);
      #1;
      if (tx_start === 1'b1) begin
        check_eq("busy_at_start", tx_busy, 1'b0);
        if (exp_q.size() == 0) begin
          check_eq("tx_spurious", tx_start, 1'b0);
        end else begin
          check_eq("sending_at_start", sending, 1'b1);
          check_eq("tx_data", tx_data, exp_q.pop_front());
        end
        tx_cnt++;
        if (arm) begin
          lat_cyc = cyc;
          arm     = 1'b0;
        end
        busy_cnt = BUSY;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
      end
      tx_busy = (busy_cnt != 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    repeat (10) tick();
    check_eq("rst_tx_start", tx_start, 1'b0);
    reset = 1'b0;
    tick();
    check_eq("rst_msg_len", msg_len, 0);
    check_eq("rst_sending", sending, 1'b0);
    check_eq("rst_overflow", overflow, 1'b0);
    check_eq("rst_tx_start_after", tx_start, 1'b0);

    press_hi();
    release_btn();
    check_eq("empty_press_sending", sending, 1'b0);
    check_eq("empty_press_len", msg_len, 0);

    send_rx(8'h55);
    send_rx(8'hAA);
    send_rx(8'h55);
    check_eq("len3", msg_len, 3);

    for (int i = 0; i < DB / 2; i++) begin
      btn_write = ((i / 4) % 2) == 0;
      tick();
    end
    btn_write = 1'b0;
    release_btn();
    check_eq("bounce_len", msg_len, 3);
    check_eq("bounce_sending", sending, 1'b0);

    btn_write = 1'b1;
    repeat (DB - 1) tick();
    btn_write = 1'b0;
    release_btn();
    check_eq("db_short_len", msg_len, 3);
    check_eq("db_short_sending", sending, 1'b0);

    base = tx_cnt;
    press_hi();
    release_btn();
    wait_done("send3_done");
    check_eq("send3_count", 32'(tx_cnt - base), 3);
    check_eq("send3_len", msg_len, 0);
    check_eq("send3_sending", sending, 1'b0);
    check_eq("send3_overflow", overflow, 1'b0);
    check_lat();

    for (int i = 1; i <= 4; i++) send_rx(8'(i));
    base = tx_cnt;
    press_hi();
    n = 0;
    while (tx_cnt == base && n < 200) begin
      tick();
      n++;
    end
    check_eq("midsend_started", n < 200, 1'b1);
    send_rx(8'h08);
    check_eq("midsend_overflow", overflow, 1'b1);
    release_btn();
    wait_done("send4_done");
    check_eq("send4_count", 32'(tx_cnt - base), 4);
    check_eq("send4_len", msg_len, 0);
    check_eq("send4_overflow_sticky", overflow, 1'b1);
    check_lat();

    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check_eq("rst2_overflow", overflow, 1'b0);
    check_eq("rst2_len", msg_len, 0);

    for (int i = 0; i < MAX_LEN + 2; i++) begin
      send_rx(8'($urandom_range(0, 255)));
      if (i == MAX_LEN - 1) begin
        check_eq("full_len", msg_len, MAX_LEN);
        check_eq("full_no_overflow", overflow, 1'b0);
      end
    end
    check_eq("over_len", msg_len, MAX_LEN);
    check_eq("over_overflow", overflow, 1'b1);
    base = tx_cnt;
    press_hi();
    release_btn();
    wait_done("sendmax_done");
    check_eq("sendmax_count", 32'(tx_cnt - base), MAX_LEN);
    check_eq("sendmax_len", msg_len, 0);
    check_lat();

    send_rx(8'h11);
    send_rx(8'h22);
    send_rx(8'h33);
    base = tx_cnt;
    press_hi();
    n = 0;
    while (tx_cnt < base + 2 && n < 300) begin
      tick();
      n++;
    end
    check_eq("reach_second_byte", n < 300, 1'b1);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check_eq("midrst_sending", sending, 1'b0);
    check_eq("midrst_len", msg_len, 0);
    check_eq("midrst_tx_start", tx_start, 1'b0);
    exp_q.delete();
    model_buf.delete();
    in_send = 1'b0;
    arm     = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    tick();

    base = tx_cnt;
    send_rx(8'hAA);
    press_hi();
    release_btn();
    wait_done("post_rst_done");
    check_eq("post_rst_count", 32'(tx_cnt - base), 1);
    check_eq("post_rst_len", msg_len, 0);
    check_eq("post_rst_sending", sending, 1'b0);
    check_lat();

    repeat (20) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
